// File: rtl/mult_seq_if.sv
// Handshake and operand/result bundle for the sequential 32x32 multiplier.
interface mult_seq_if;
  logic        start;
  logic [1:0]  sign;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] multHI;
  logic [31:0] multLO;
  logic        busy;
  logic        done;

  modport master (
    output start, sign, multiplicand, multiplier,
    input  multHI, multLO, busy, done
  );

  modport slave (
    input  start, sign, multiplicand, multiplier,
    output multHI, multLO, busy, done
  );
endinterface

// File: rtl/mult_seq.sv
// Radix-2 shift-add 32x32 multiplier with fixed 33-cycle latency.
// Signed mode multiplies magnitudes and negates the 64-bit product at the end.
module mult_seq (
  input  logic       clk,
  input  logic       reset,
  mult_seq_if.slave  bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state, state_d;
  logic [W-1:0]    mcand;
  logic [W-1:0]    p_hi, p_lo;
  logic [CW-1:0]   cnt;
  logic            negate;

  logic            load_c;
  logic [W-1:0]    a_mag_c, b_mag_c;
  logic [W:0]      sum_c;
  logic [2*W-1:0]  result_c;
  logic            unused_sign0;

  assign unused_sign0 = bus.sign[0];

  // Next-state logic
  always_comb begin
    state_d = state;
    load_c  = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_d = RUN;
        load_c  = 1'b1;
      end
      RUN:  if (cnt == CW'(W - 1)) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Operand magnitudes, one add-and-shift step, and final sign fix-up
  always_comb begin
    a_mag_c = bus.multiplicand;
    b_mag_c = bus.multiplier;
    if (bus.sign[1] && bus.multiplicand[W-1]) a_mag_c = W'(~bus.multiplicand + W'(1));
    if (bus.sign[1] && bus.multiplier[W-1])   b_mag_c = W'(~bus.multiplier + W'(1));
    sum_c    = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : (W+1)'(0));
    result_c = negate ? (2*W)'(~{p_hi, p_lo} + (2*W)'(1)) : {p_hi, p_lo};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand      <= '0;
      p_hi       <= '0;
      p_lo       <= '0;
      cnt        <= '0;
      negate     <= 1'b0;
      bus.multHI <= '0;
      bus.multLO <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.busy <= (state_d != IDLE);
      bus.done <= (state == FIN);
      if (load_c) begin
        mcand  <= a_mag_c;
        p_hi   <= '0;
        p_lo   <= b_mag_c;
        cnt    <= '0;
        negate <= bus.sign[1] & (bus.multiplicand[W-1] ^ bus.multiplier[W-1]);
      end else if (state == RUN) begin
        {p_hi, p_lo} <= {sum_c, p_lo[W-1:1]};
        cnt          <= cnt + CW'(1);
      end else if (state == FIN) begin
        {bus.multHI, bus.multLO} <= result_c;
      end
    end
  end
endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed vector table, corner sequences,
// and randomized back-to-back operations against an arithmetic reference.
module tb_mult_seq;
  logic clk = 1'b0;
  logic reset;
  mult_seq_if bus ();

  mult_seq u_dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [63:0] ref_mul(input logic [1:0] s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub;
    if (s[1]) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic launch(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    bus.sign         = s;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
  endtask

  // Called right after launch; checks latency, busy, result hold and value.
  // inject>0 re-asserts start with other operands at that RUN cycle.
  task automatic finish_op(input string nm, input logic [63:0] exp, input int inject);
    logic [63:0] held;
    int n;
    bit seen, steady;
    held = {bus.multHI, bus.multLO};
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, " busy_after_start"}, 64'(bus.busy), 64'd1);
    chk({nm, " done_after_start"}, 64'(bus.done), 64'd0);
    seen = 1'b0; steady = 1'b1; n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (inject > 0 && n == inject)
        launch(2'b10, $urandom, $urandom);
      if (inject > 0 && n == inject + 2) bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
      else if ({bus.multHI, bus.multLO} !== held || bus.busy !== 1'b1) steady = 1'b0;
    end
    chk({nm, " latency"}, 64'(n), 64'd33);
    chk({nm, " busy_hold_during_run"}, 64'(steady), 64'd1);
    chk({nm, " busy_in_done"}, 64'(bus.busy), 64'd0);
    chk({nm, " product"}, {bus.multHI, bus.multLO}, exp);
  endtask

  initial begin
    vec_t vecs[9];
    logic [1:0]  rs;
    logic [31:0] ra, rb;
    bit got_done;

    vecs[0] = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A};
    vecs[1] = '{2'b10, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5] = '{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[8] = '{2'b10, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};

    reset = 1'b1;
    bus.start = 1'b0; bus.sign = 2'b00;
    bus.multiplicand = '0; bus.multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset product", {bus.multHI, bus.multLO}, 64'd0);

    // Start accepted on first edge after reset release; then back-to-back table
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].sign, vecs[i].a, vecs[i].b);
      finish_op($sformatf("vec%0d", i), {vecs[i].hi, vecs[i].lo}, 0);
    end

    // Start during RUN with different operands must be ignored
    launch(2'b00, 32'd1000, 32'd3);
    finish_op("ignore_start", 64'd3000, 10);

    // Reset sampled at the 10th RUN edge aborts the operation
    repeat (2) @(posedge clk);
    #1;
    launch(2'b00, 32'd5, 32'd5);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort product", {bus.multHI, bus.multLO}, 64'd0);
    reset = 1'b0;
    got_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) got_done = 1'b1;
    end
    chk("abort no_done", 64'(got_done), 64'd0);
    launch(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFA);
    finish_op("after_abort", 64'd42, 0);

    // Randomized back-to-back operations
    for (int i = 0; i < 40; i++) begin
      rs = 2'($urandom);
      ra = $urandom;
      rb = (i % 8 == 0) ? 32'h8000_0000 : $urandom;
      launch(rs, ra, rb);
      finish_op($sformatf("rand%0d", i), ref_mul(rs, ra, rb), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
